ir_nec_receiver: RTL and testbench

- Fully synchronous, parametrised successor to the existing IR decode path.
- Samples the demodulated IR line on the system clock and measures mark/space durations with a prescaled timer.
- Decodes NEC-style frames of SIGNAL_WIDTH bits, plus repeat codes, and delivers the code word with valid, repeat, error and checksum flags.
- Feeds the existing ir_code_decoder/checksum consumers through o_code; no logic is clocked from the IR line itself.

---
 rtl/ir_pkg.sv | 35 +++
 rtl/ir_pulse_timer.sv | 76 +++++++
 rtl/ir_nec_receiver.sv | 189 ++++++++++++++++++
 tb/tb_ir_nec_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and timing windows for the NEC IR receiver.
// Windows are in quarter-unit (q) ticks, inclusive.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_REP_STOP
    } ir_state_t;

    localparam logic [7:0] LEAD_MARK_MIN   = 8'd48;
    localparam logic [7:0] LEAD_MARK_MAX   = 8'd80;
    localparam logic [7:0] FRAME_SPACE_MIN = 8'd24;
    localparam logic [7:0] FRAME_SPACE_MAX = 8'd40;
    localparam logic [7:0] REP_SPACE_MIN   = 8'd12;
    localparam logic [7:0] REP_SPACE_MAX   = 8'd20;
    localparam logic [7:0] BIT_MIN         = 8'd2;
    localparam logic [7:0] BIT_MAX         = 8'd6;
    localparam logic [7:0] ONE_MIN         = 8'd9;
    localparam logic [7:0] ONE_MAX         = 8'd15;
    localparam logic [7:0] DUR_SAT         = 8'd255;

    function automatic logic in_win(
        input logic [7:0] d,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchroniser, edge detect and quarter-unit duration counter.
// rise/fall are registered; dur carries the pre-clear count alongside them.
module ir_pulse_timer
#(
    parameter int UNIT_CYCLES = 28125,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ir_signal,
    output logic       o_mark,
    output logic       o_rise,
    output logic       o_fall,
    output logic [7:0] o_dur
);
    import ir_pkg::*;

    localparam int   PRE      = UNIT_CYCLES / 4;
    localparam int   PW       = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   mark_q, mark_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [7:0]             dur_q, dur_d;
    logic [7:0]             dout_q, dout_d;
    logic                   edge_w;
    logic                   tick;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_ir_signal};
        mark_d = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
        edge_w = mark_d ^ mark_q;
        rise_d = mark_d & ~mark_q;
        fall_d = ~mark_d & mark_q;
        tick   = (pre_q == PW'(PRE - 1));
        dout_d = dur_q;
        // The edge cycle itself counts as the first cycle of the new interval.
        if (edge_w) begin
            pre_d = PW'(1);
            dur_d = '0;
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            dur_d = (tick && dur_q != DUR_SAT) ? dur_q + 8'd1 : dur_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            mark_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pre_q  <= '0;
            dur_q  <= '0;
            dout_q <= '0;
        end else begin
            sync_q <= sync_d;
            mark_q <= mark_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pre_q  <= pre_d;
            dur_q  <= dur_d;
            dout_q <= dout_d;
        end
    end

    assign o_mark = mark_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_dur  = dout_q;

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame/repeat decoder: FSM, LSB-first shifter and checksum.
// All logic runs on i_clk; the IR line only enters through the timer.
module ir_nec_receiver
#(
    parameter int UNIT_CYCLES   = 28125,
    parameter int SIGNAL_WIDTH  = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 1,
    parameter int CHECK_INVERSE = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ir_signal,
    output logic [SIGNAL_WIDTH-1:0] o_code,
    output logic                    o_valid,
    output logic                    o_repeat,
    output logic                    o_error,
    output logic                    o_checksum_valid,
    output logic                    o_busy
);
    import ir_pkg::*;

    localparam logic CSUM_EN = (CHECK_INVERSE != 0) && (SIGNAL_WIDTH == 32);
    localparam int   CW      = $clog2(SIGNAL_WIDTH + 1);

    logic       mark, rise, fall;
    logic [7:0] dur;

    ir_pulse_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ir_signal (i_ir_signal),
        .o_mark      (mark),
        .o_rise      (rise),
        .o_fall      (fall),
        .o_dur       (dur)
    );

    ir_state_t               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SIGNAL_WIDTH-1:0] shift_q, shift_d;
    logic [SIGNAL_WIDTH-1:0] code_q, code_d;
    logic                    csum_q, csum_d;
    logic                    have_q, have_d;
    logic                    valid_q, valid_d;
    logic                    rep_q, rep_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    bad;
    logic                    is_zero, is_one, is_bit;
    logic [31:0]             sh32;
    logic                    csum_ok;

    assign is_zero = in_win(dur, BIT_MIN, BIT_MAX);
    assign is_one  = in_win(dur, ONE_MIN, ONE_MAX);
    assign is_bit  = is_zero;
    assign sh32    = 32'(shift_q);
    assign csum_ok = CSUM_EN ? ((sh32[15:8] == ~sh32[7:0]) &&
                                (sh32[31:24] == ~sh32[23:16])) : 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        code_d  = code_q;
        csum_d  = csum_q;
        have_d  = have_q;
        valid_d = 1'b0;
        rep_d   = 1'b0;
        err_d   = 1'b0;
        bad     = 1'b0;
        if (state_q != S_IDLE && dur == DUR_SAT) begin
            bad = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise && mark) state_d = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    if (fall) begin
                        if (in_win(dur, LEAD_MARK_MIN, LEAD_MARK_MAX))
                            state_d = S_LEAD_SPACE;
                        else
                            bad = 1'b1;
                    end
                end
                S_LEAD_SPACE: begin
                    if (rise) begin
                        if (in_win(dur, FRAME_SPACE_MIN, FRAME_SPACE_MAX)) begin
                            state_d = S_BIT_MARK;
                            cnt_d   = '0;
                        end else if (in_win(dur, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                            state_d = S_REP_STOP;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (fall) begin
                        if (is_bit) state_d = S_BIT_SPACE;
                        else        bad = 1'b1;
                    end
                end
                S_BIT_SPACE: begin
                    if (rise) begin
                        if (is_zero || is_one) begin
                            shift_d = {is_one, shift_q[SIGNAL_WIDTH-1:1]};
                            cnt_d   = cnt_q + CW'(1);
                            state_d = (cnt_d == CW'(SIGNAL_WIDTH)) ?
                                      S_STOP_MARK : S_BIT_MARK;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (fall) begin
                        if (is_bit) begin
                            code_d  = shift_q;
                            csum_d  = csum_ok;
                            have_d  = 1'b1;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                S_REP_STOP: begin
                    if (fall) begin
                        if (is_bit) begin
                            // A repeat with nothing to repeat is malformed.
                            rep_d   = have_q;
                            err_d   = ~have_q;
                            state_d = S_IDLE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (bad) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            csum_q  <= ~CSUM_EN;
            have_q  <= 1'b0;
            valid_q <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            csum_q  <= csum_d;
            have_q  <= have_d;
            valid_q <= valid_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_code           = code_q;
    assign o_valid          = valid_q;
    assign o_repeat         = rep_q;
    assign o_error          = err_q;
    assign o_checksum_valid = csum_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Scoreboard bench for ir_nec_receiver with UNIT_CYCLES=8 (1 q = 2 clk).
// Stimulus pushes expected pulses; a monitor pops them on each DUT pulse.
module tb_ir_nec_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir  = 1'b1;
    logic [31:0] o_code;
    logic        o_valid, o_repeat, o_error, o_checksum_valid, o_busy;

    ir_nec_receiver #(
        .UNIT_CYCLES   (8),
        .SIGNAL_WIDTH  (32),
        .SYNC_STAGES   (2),
        .ACTIVE_LOW    (1),
        .CHECK_INVERSE (1)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_ir_signal      (ir),
        .o_code           (o_code),
        .o_valid          (o_valid),
        .o_repeat         (o_repeat),
        .o_error          (o_error),
        .o_checksum_valid (o_checksum_valid),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] code;
        logic        csum;
    } ev_t;

    ev_t         q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] cur_code = '0;
    logic        cur_csum = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (o_valid || o_repeat || o_error)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got v/r/e=%b%b%b expected none",
                         o_valid, o_repeat, o_error);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("pulse_kind", {o_valid, o_repeat, o_error}, e.kind);
                chk("pulse_code", o_code, e.code);
                chk("pulse_csum", o_checksum_valid, e.csum);
            end
        end
    end

    task automatic exp_valid(input logic [31:0] c, input logic cs);
        q.push_back('{3'b100, c, cs});
        cur_code = c;
        cur_csum = cs;
    endtask

    task automatic exp_rep();
        q.push_back('{3'b010, cur_code, cur_csum});
    endtask

    task automatic exp_err();
        q.push_back('{3'b001, cur_code, cur_csum});
    endtask

    task automatic idle(input int n);
        ir = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark_q(input int nq);
        ir = 1'b0;
        repeat (2 * nq) @(negedge clk);
    endtask

    task automatic space_q(input int nq);
        ir = 1'b1;
        repeat (2 * nq) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] c, input int lead,
                              input int bad_bit, input int stop_bit);
        mark_q(lead);
        space_q(32);
        for (int i = 0; i < 32; i++) begin
            mark_q(4);
            if (i == stop_bit) begin
                space_q(2);
                return;
            end
            if (i == bad_bit) begin
                space_q(24);
                mark_q(4);
                idle(40);
                return;
            end
            space_q(c[i] ? 12 : 4);
        end
        mark_q(4);
        idle(40);
    endtask

    task automatic send_repeat();
        mark_q(64);
        space_q(16);
        mark_q(4);
        idle(40);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_code"},  o_code, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_rep"},   o_repeat, 0);
        chk({tag, "_err"},   o_error, 0);
        chk({tag, "_csum"},  o_checksum_valid, 0);
        chk({tag, "_busy"},  o_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        idle(10);

        exp_valid(32'hF708FB04, 1'b1);
        send_frame(32'hF708FB04, 64, -1, -1);
        chk("busy_after_frame", o_busy, 0);

        exp_valid(32'hF608FB04, 1'b0);
        send_frame(32'hF608FB04, 64, -1, -1);

        exp_rep();
        send_repeat();

        exp_err();
        send_frame(32'hF708FB04, 64, 5, -1);
        chk("busy_after_bad_bit", o_busy, 0);

        exp_err();
        mark_q(300);
        idle(40);

        exp_err();
        ir = 1'b0;
        @(negedge clk);
        idle(40);

        exp_err();
        mark_q(47);
        idle(40);
        exp_err();
        mark_q(81);
        idle(40);
        exp_valid(32'h00FF00FF, 1'b1);
        send_frame(32'h00FF00FF, 48, -1, -1);
        exp_valid(32'hEF10BF40, 1'b1);
        send_frame(32'hEF10BF40, 80, -1, -1);

        send_frame(32'hF708FB04, 64, -1, 20);
        chk("busy_mid_frame", o_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        cur_code = '0;
        cur_csum = 1'b0;
        @(negedge clk);
        ir = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(10);

        exp_err();
        send_repeat();

        exp_valid(32'h1AE5A55A, 1'b1);
        send_frame(32'h1AE5A55A, 64, -1, -1);

        idle(20);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
